dmem_port: RTL and testbench

Data-memory responder for the core's load/store interface. It accepts one request at a time from the instruction decoder/execute stage: a memory enable, write enable, byte address, lane mask (0001/0011/1111) and a sign-extend flag. It converts each request into a word-addressed, byte-enabled access to the data memory and waits for the memory's acknowledge. Loads return lane-aligned, zero- or sign-extended data.

---
 rtl/dmem_port.sv | 194 +++++++++++++++++++
 tb/tb_dmem_port.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// dmem_port: load/store responder between the execute stage and a
// word-addressed, byte-enabled data memory. One request in flight at a time.
// Optional build macro: DMEM_MISALIGN_CHECK_EN rejects misaligned half/word
// requests with an error instead of issuing them to memory.
module dmem_port #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  mask_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    // Counter only needs to reach TIMEOUT-1; the cycle that hits it is the last ACCESS cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    // Any mask other than byte/half encodings is handled as a full word.
    function automatic size_e decode_size(input logic [3:0] mask);
        case (mask)
            4'b0001: return SZ_BYTE;
            4'b0011: return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Lane mask shifted to the byte offset; lanes past byte 3 fall off the top.
    function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] off);
        logic [6:0] wide;
        case (sz)
            SZ_BYTE: wide = 7'b000_0001;
            SZ_HALF: wide = 7'b000_0011;
            default: wide = 7'b000_1111;
        endcase
        wide = wide << off;
        return wide[3:0];
    endfunction

    // Right-align the addressed lanes, then zero- or sign-extend to 32 bits.
    function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] off,
                                               input size_e sz, input logic sext);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (sz)
            SZ_BYTE: return {{24{sext & sh[7]}}, sh[7:0]};
            SZ_HALF: return {{16{sext & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_e           state_q, state_d;
    size_e            size_q, size_d;
    logic             we_q, we_d;
    logic             sext_q, sext_d;
    logic [1:0]       off_q, off_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    size_e            req_size;
    logic             misalign;

    assign req_size = decode_size(mask_i);

`ifdef DMEM_MISALIGN_CHECK_EN
    // Half needs an even address, word needs a word-aligned address.
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            SZ_HALF: misalign = addr_i[0];
            SZ_WORD: misalign = (addr_i[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // State register and request/response holding registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, wait for ack or timeout in ACCESS, pulse in RESP.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        we_d    = we_q;
        sext_d  = sext_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = req_size;
                    sext_d  = sext_i;
                    off_d   = addr_i[1:0];
                    waddr_d = addr_i[31:2];
                    be_d    = lane_be(req_size, addr_i[1:0]);
                    wdata_d = wdata_i << {addr_i[1:0], 3'b000};
                    cnt_d   = '0;
                    err_d   = misalign;
                    state_d = misalign ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = load_align(mem_rdata_i, off_q, size_q, sext_q);
                    end
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset drops the strobe at once.
    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = (state_q == S_RESP);
    assign err_o       = done_o & err_q;
    assign mem_cs_o    = (state_q == S_ACCESS);
    assign mem_we_o    = mem_cs_o & we_q;
    assign mem_addr_o  = waddr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: reset state, a table of directed
// transactions, misalignment handling, spurious acks, randomized traffic
// against a byte-level reference model, and reset in the middle of an access.
module tb_dmem_port;

    localparam int TO = 15;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, sext_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  mask_i;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_cs_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    dmem_port #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .mask_i(mask_i), .sext_i(sext_i), .wdata_i(wdata_i), .ready_o(ready_o),
        .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .mem_cs_o(mem_cs_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          cs;
        int          done_cyc;
        logic        err;
        logic [31:0] rdata;
        logic        unstable;
        logic        ready_after;
        logic        done_after;
    } act_t;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cs;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          delay;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rdata;
        logic        err;
        int          cs;
    } vec_t;

    // Reference model: byte-by-byte lane placement, timeout and misalignment rules.
    function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                                   input logic sext, input logic [31:0] wdata, input logic [31:0] mrd,
                                   input int delay, input logic [31:0] prev);
        exp_t e;
        int nb, off;
        bit mis, tmo;
        logic [31:0] val;
        nb  = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (nb == 2 && (off % 2) == 1) || (nb == 4 && off != 0);
`endif
        e.be = '0; e.wdata = '0; val = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) e.be[i] = 1'b1;
            if (i >= off) e.wdata[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
        for (int j = 0; j < nb; j++)
            if (j + off < 4) val[8*j +: 8] = mrd[8*(j+off) +: 8];
        if (sext && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        tmo   = (delay < 0) || (delay >= TO);
        e.err = mis || tmo;
        if (mis)      begin e.cs = 0;         e.done_cyc = 1; end
        else if (tmo) begin e.cs = TO;        e.done_cyc = TO + 1; end
        else          begin e.cs = delay + 1; e.done_cyc = delay + 2; end
        e.rdata = (!we && !e.err) ? val : prev;
        return e;
    endfunction

    // Issue one request from an idle negedge and act as the memory; delay<0 = never ack.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic sext, input logic [31:0] wdata, input logic [31:0] mrd,
                          input int delay, input bit poke, output act_t a);
        int c, cs;
        a.be = '0; a.addr = '0; a.wdata = '0; a.we = 1'b0; a.err = 1'b0; a.rdata = '0;
        a.unstable = 1'b0; a.done_cyc = -1; a.ready_after = 1'b0; a.done_after = 1'b0;
        req_i = 1'b1; we_i = we; addr_i = addr; mask_i = mask; sext_i = sext; wdata_i = wdata;
        c = 0; cs = 0;
        while (c < 100) begin
            @(negedge clk_i);
            c++;
            req_i = poke;
            if (poke) addr_i = 32'hFFFF_FFF0;
            mem_ack_i = 1'b0;
            mem_rdata_i = 32'h5A5A_5A5A;
            if (mem_cs_o) begin
                if (cs == 0) begin
                    a.be = mem_be_o; a.addr = mem_addr_o; a.wdata = mem_wdata_o; a.we = mem_we_o;
                end else if (mem_be_o != a.be || mem_addr_o != a.addr ||
                             mem_wdata_o != a.wdata || mem_we_o != a.we) begin
                    a.unstable = 1'b1;
                end
                if (cs == delay) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = mrd;
                end
                cs++;
            end
            if (done_o) begin
                a.done_cyc = c; a.err = err_o; a.rdata = rdata_o;
                break;
            end
        end
        a.cs = cs;
        @(negedge clk_i);
        req_i = 1'b0; mem_ack_i = 1'b0;
        a.ready_after = ready_o;
        a.done_after  = done_o;
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] addr,
                             input exp_t e, input act_t a);
        chk({tag, ".err"}, a.err, e.err);
        chk({tag, ".rdata"}, a.rdata, e.rdata);
        chk({tag, ".cs_cycles"}, a.cs, e.cs);
        chk({tag, ".done_cycle"}, a.done_cyc, e.done_cyc);
        chk({tag, ".ready_after"}, a.ready_after, 1'b1);
        chk({tag, ".done_after"}, a.done_after, 1'b0);
        if (e.cs > 0) begin
            chk({tag, ".be"}, a.be, e.be);
            chk({tag, ".mem_addr"}, a.addr, addr >> 2);
            chk({tag, ".mem_we"}, a.we, we);
            chk({tag, ".stable"}, a.unstable, 1'b0);
            if (we) chk({tag, ".mem_wdata"}, a.wdata, e.wdata);
        end
    endtask

    vec_t tbl[13];
    act_t a;
    exp_t e;
    logic [31:0] exp_rd;
    int dones;

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; mask_i = '0; sext_i = 1'b0;
        wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        //          we    addr      mask   sext  wdata          mrd           dly  be     mwd            rdata          err  cs
        tbl[0]  = '{1'b1, 32'h100, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0,        0,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1};
        tbl[1]  = '{1'b0, 32'h100, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF, 0,  4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1};
        tbl[2]  = '{1'b1, 32'h103, 4'h1, 1'b0, 32'h000000A5, 32'h0,        0,  4'h8, 32'hA5000000, 32'hDEADBEEF, 1'b0, 1};
        tbl[3]  = '{1'b0, 32'h103, 4'h1, 1'b1, 32'h0,        32'hA5000000, 0,  4'h8, 32'h0,        32'hFFFFFFA5, 1'b0, 1};
        tbl[4]  = '{1'b0, 32'h103, 4'h1, 1'b0, 32'h0,        32'hA5000000, 0,  4'h8, 32'h0,        32'h000000A5, 1'b0, 1};
        tbl[5]  = '{1'b0, 32'h102, 4'h3, 1'b1, 32'h0,        32'h80011234, 0,  4'hC, 32'h0,        32'hFFFF8001, 1'b0, 1};
        tbl[6]  = '{1'b0, 32'h102, 4'h3, 1'b0, 32'h0,        32'h80011234, 0,  4'hC, 32'h0,        32'h00008001, 1'b0, 1};
        tbl[7]  = '{1'b0, 32'h200, 4'hF, 1'b0, 32'h0,        32'h12345678, 5,  4'hF, 32'h0,        32'h12345678, 1'b0, 6};
        tbl[8]  = '{1'b0, 32'h204, 4'hF, 1'b0, 32'h0,        32'h0,        -1, 4'hF, 32'h0,        32'h12345678, 1'b1, 15};
        tbl[9]  = '{1'b0, 32'h300, 4'h5, 1'b0, 32'h0,        32'hCAFEF00D, 1,  4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 2};
        tbl[10] = '{1'b0, 32'h101, 4'h1, 1'b1, 32'h0,        32'h00008000, 0,  4'h2, 32'h0,        32'hFFFFFF80, 1'b0, 1};
        tbl[11] = '{1'b1, 32'h002, 4'h3, 1'b0, 32'h1234ABCD, 32'h0,        2,  4'hC, 32'hABCD0000, 32'hFFFFFF80, 1'b0, 3};
        tbl[12] = '{1'b0, 32'h400, 4'hF, 1'b0, 32'h0,        32'h0BADCAFE, 14, 4'hF, 32'h0,        32'h0BADCAFE, 1'b0, 15};

        // Reset state, both during and after reset.
        repeat (3) @(negedge clk_i);
        chk("rst.ready", ready_o, 1'b1);
        chk("rst.done", done_o, 1'b0);
        chk("rst.cs", mem_cs_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst.err", err_o, 1'b0);
        chk("rst.mem_we", mem_we_o, 1'b0);
        chk("rst.rdata", rdata_o, 32'h0);
        chk("rst.mem_addr", mem_addr_o, 30'h0);
        chk("rst.mem_be", mem_be_o, 4'h0);
        chk("rst.mem_wdata", mem_wdata_o, 32'h0);
        chk("rst.ready_after", ready_o, 1'b1);

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].sext, tbl[i].wdata,
                   tbl[i].mrd, tbl[i].delay, 1'b0, a);
            e.be = tbl[i].be; e.wdata = tbl[i].mwd; e.rdata = tbl[i].rdata;
            e.err = tbl[i].err; e.cs = tbl[i].cs; e.done_cyc = tbl[i].cs + 1;
            check_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, e, a);
        end
        exp_rd = 32'h0BADCAFE;

        // Misaligned requests.
`ifdef DMEM_MISALIGN_CHECK_EN
        do_req(1'b0, 32'h102, 4'hF, 1'b0, 32'h0, 32'h11111111, 0, 1'b0, a);
        e = '{be: 4'h0, wdata: 32'h0, rdata: exp_rd, err: 1'b1, cs: 0, done_cyc: 1};
        check_txn("mis.lw102", 1'b0, 32'h102, e, a);
        do_req(1'b0, 32'h101, 4'h3, 1'b1, 32'h0, 32'h11111111, 0, 1'b0, a);
        check_txn("mis.lh101", 1'b0, 32'h101, e, a);
`else
        do_req(1'b1, 32'h103, 4'h3, 1'b0, 32'h1234ABCD, 32'h0, 0, 1'b0, a);
        e = '{be: 4'h8, wdata: 32'hCD000000, rdata: exp_rd, err: 1'b0, cs: 1, done_cyc: 2};
        check_txn("mis.sh103", 1'b1, 32'h103, e, a);
        do_req(1'b0, 32'h103, 4'h3, 1'b1, 32'h0, 32'hAB0000FF, 0, 1'b0, a);
        e = '{be: 4'h8, wdata: 32'h0, rdata: 32'h000000AB, err: 1'b0, cs: 1, done_cyc: 2};
        check_txn("mis.lh103", 1'b0, 32'h103, e, a);
        exp_rd = 32'h000000AB;
`endif

        // Acks while idle must not start or complete anything.
        mem_ack_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("idle_ack.done", done_o, 1'b0);
            chk("idle_ack.cs", mem_cs_o, 1'b0);
        end
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ack.rdata", rdata_o, exp_rd);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic        rwe, rsx;
            logic [31:0] raddr, rwd, rmrd;
            logic [3:0]  rmask;
            int          r, dly;
            rwe   = 1'($urandom_range(0, 1));
            rsx   = 1'($urandom_range(0, 1));
            raddr = {20'h0, 12'($urandom)};
            rwd   = $urandom;
            rmrd  = $urandom;
            case ($urandom_range(0, 3))
                0: rmask = 4'b0001;
                1: rmask = 4'b0011;
                2: rmask = 4'b1111;
                default: rmask = 4'($urandom);
            endcase
            r = int'($urandom_range(0, 9));
            if (r < 6)      dly = r % 4;
            else if (r < 8) dly = TO - 2 + (r - 6);
            else            dly = -1;
            e = model(rwe, raddr, rmask, rsx, rwd, rmrd, dly, exp_rd);
            do_req(rwe, raddr, rmask, rsx, rwd, rmrd, dly, 1'b0, a);
            check_txn($sformatf("rnd%0d", n), rwe, raddr, e, a);
            exp_rd = e.rdata;
        end

        // Asynchronous reset in the middle of an access.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h500; mask_i = 4'hF; sext_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid.cs_before", mem_cs_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstmid.cs", mem_cs_o, 1'b0);
        chk("rstmid.ready", ready_o, 1'b1);
        chk("rstmid.done", done_o, 1'b0);
        chk("rstmid.rdata", rdata_o, 32'h0);
        dones = 0;
        repeat (2) begin @(negedge clk_i); if (done_o) dones++; end
        rst_ni = 1'b1;
        repeat (2) begin @(negedge clk_i); if (done_o) dones++; end
        chk("rstmid.no_done", dones, 0);
        chk("rstmid.ready_after", ready_o, 1'b1);
        exp_rd = 32'h0;

        // New load after reset, with req pulses while busy that must be ignored.
        do_req(1'b0, 32'h504, 4'hF, 1'b0, 32'h0, 32'h11223344, 2, 1'b1, a);
        e = model(1'b0, 32'h504, 4'hF, 1'b0, 32'h0, 32'h11223344, 2, exp_rd);
        check_txn("post_rst", 1'b0, 32'h504, e, a);
        @(negedge clk_i);
        chk("poke.no_access", mem_cs_o, 1'b0);
        chk("poke.ready", ready_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
